// File: rtl/ee201_gcd_scheduler.sv
// Two-requester round-robin job scheduler in front of an external GCD unit.
// Optional macro GCD_ZERO_CHECK_EN: jobs with a zero operand bypass the GCD unit.
module ee201_gcd_scheduler #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Req0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] A0,
   input  logic [WIDTH-1:0] B0,
   input  logic [WIDTH-1:0] A1,
   input  logic [WIDTH-1:0] B1,
   output logic             Grant0,
   output logic             Grant1,
   output logic             Rdy0,
   output logic             Rdy1,
   input  logic             Rack0,
   input  logic             Rack1,
   output logic [WIDTH-1:0] Result,
   output logic [CNT_W-1:0] Cycles,
   output logic             Owner,
   output logic             Busy,
   output logic             gcd_Start,
   output logic             gcd_Ack,
   output logic [WIDTH-1:0] gcd_Ain,
   output logic [WIDTH-1:0] gcd_Bin,
   input  logic             gcd_Done,
   input  logic [WIDTH-1:0] gcd_Result
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, ACK, DELIVER} state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             prio_q, prio_d;
   logic             grant0_q, grant0_d;
   logic             grant1_q, grant1_d;
   logic             rdy0_q, rdy0_d;
   logic             rdy1_q, rdy1_d;
   logic             start_q, start_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [WIDTH-1:0] ain_q, ain_d;
   logic [WIDTH-1:0] bin_q, bin_d;

   // prio_q names the requester that wins a simultaneous request.
   logic             win;
   logic [WIDTH-1:0] sel_a, sel_b;

   assign win   = (Req0 && Req1) ? prio_q : Req1;
   assign sel_a = win ? A1 : A0;
   assign sel_b = win ? B1 : B0;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      prio_d   = prio_q;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      rdy0_d   = rdy0_q;
      rdy1_d   = rdy1_q;
      start_d  = 1'b0;
      ack_d    = 1'b0;
      result_d = result_q;
      cycles_d = cycles_q;
      ain_d    = ain_q;
      bin_d    = bin_q;

      case (state_q)
         IDLE: begin
            if (Req0 || Req1) begin
               ain_d    = sel_a;
               bin_d    = sel_b;
               owner_d  = win;
               grant0_d = !win;
               grant1_d = win;
               cycles_d = '0;
`ifdef GCD_ZERO_CHECK_EN
               if (sel_a == '0 || sel_b == '0) begin
                  result_d = sel_a | sel_b;
                  rdy0_d   = !win;
                  rdy1_d   = win;
                  state_d  = DELIVER;
               end else
`endif
               begin
                  start_d = 1'b1;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            cycles_d = '0;
            state_d  = RUN;
         end
         RUN: begin
            // The cycle that samples gcd_Done is itself counted.
            if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
            if (gcd_Done) begin
               result_d = gcd_Result;
               ack_d    = 1'b1;
               state_d  = ACK;
            end
         end
         ACK: begin
            rdy0_d  = !owner_q;
            rdy1_d  = owner_q;
            state_d = DELIVER;
         end
         DELIVER: begin
            if (owner_q ? Rack1 : Rack0) begin
               rdy0_d  = 1'b0;
               rdy1_d  = 1'b0;
               prio_d  = !owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: state is updated with non-blocking assignments only; every *_d above
   // gets a default first so the combinational block never infers a latch.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         prio_q   <= 1'b0;
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         rdy0_q   <= 1'b0;
         rdy1_q   <= 1'b0;
         start_q  <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
         cycles_q <= '0;
         ain_q    <= '0;
         bin_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         prio_q   <= prio_d;
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         rdy0_q   <= rdy0_d;
         rdy1_q   <= rdy1_d;
         start_q  <= start_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         cycles_q <= cycles_d;
         ain_q    <= ain_d;
         bin_q    <= bin_d;
      end
   end

   assign Grant0    = grant0_q;
   assign Grant1    = grant1_q;
   assign Rdy0      = rdy0_q;
   assign Rdy1      = rdy1_q;
   assign gcd_Start = start_q;
   assign gcd_Ack   = ack_q;
   assign Busy      = busy_q;
   assign Owner     = owner_q;
   assign Result    = result_q;
   assign Cycles    = cycles_q;
   assign gcd_Ain   = ain_q;
   assign gcd_Bin   = bin_q;

endmodule

// File: doc/ee201_gcd_scheduler.md
EE201_GCD_SCHEDULER -- requirements
Module: ee201_gcd_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 16: width of the job cycle counter.
REQ-003 SHALL have port Clk  in  1: single clock, all state on rising edge.
REQ-004 SHALL have port Reset  in  1: asynchronous, active-low reset.
REQ-005 SHALL have ports Req0, Req1  in  1: job requests from requester 0 and 1.
REQ-006 SHALL have ports A0, B0, A1, B1  in  WIDTH: per-requester operands.
REQ-007 SHALL have ports Grant0, Grant1  out  1: one-cycle pulse, operands captured.
REQ-008 SHALL have ports Rdy0, Rdy1  out  1: result valid for that requester.
REQ-009 SHALL have ports Rack0, Rack1  in  1: requester accepts result.
REQ-010 SHALL have ports Result  out  WIDTH, Cycles  out  CNT_W, Owner  out  1, Busy  out  1.
REQ-011 SHALL have ports gcd_Start, gcd_Ack  out  1, gcd_Ain, gcd_Bin  out  WIDTH: GCD unit controls.
REQ-012 SHALL have ports gcd_Done  in  1, gcd_Result  in  WIDTH: GCD unit status and result.

Function
REQ-013 SHALL implement states IDLE, LOAD, RUN, ACK, DELIVER; all outputs registered.
REQ-014 IDLE: any Req high -> capture winner's operands into gcd_Ain/gcd_Bin, set Owner, go LOAD; no Req -> stay.
REQ-015 Arbitration SHALL be round-robin: on simultaneous Req0/Req1, the requester not served last wins; after reset, requester 0 wins.
REQ-016 Req SHALL be sampled only in IDLE; Req in other states is ignored and not queued.
REQ-017 LOAD: Grant of Owner and gcd_Start high for exactly this one cycle; Cycles cleared to 0; next state RUN.
REQ-018 RUN: Cycles increments once per cycle, saturating at all-ones; on gcd_Done high, latch gcd_Result into Result, go ACK.
REQ-019 The RUN cycle in which gcd_Done is sampled SHALL be counted in Cycles.
REQ-020 ACK: gcd_Ack high for exactly one cycle; next state DELIVER.
REQ-021 DELIVER: Rdy of Owner high and held, Result/Cycles stable, until Rack of Owner is sampled high; then go IDLE and record Owner as last served.
REQ-022 Rack of the non-owner, or any Rack outside DELIVER, SHALL be ignored.
REQ-023 Busy SHALL be high in every state except IDLE.
REQ-024 gcd_Ain/gcd_Bin SHALL remain stable from LOAD until next capture in IDLE.

Reset
REQ-025 Reset low SHALL immediately force IDLE, regardless of current state.
REQ-026 On reset all outputs SHALL be 0 (Grant, Rdy, gcd_Start, gcd_Ack, Busy, Owner, Result, Cycles, gcd_Ain, gcd_Bin); round-robin favours requester 0.
REQ-027 A job in progress at reset SHALL be discarded with no Rdy issued.

Configuration
REQ-028 Macro GCD_ZERO_CHECK_EN defined: in IDLE, if either captured operand is 0, skip LOAD/RUN/ACK, pulse Grant one cycle, go DELIVER with Result = A|B, Cycles = 0, no gcd_Start.
REQ-029 Macro GCD_ZERO_CHECK_EN undefined: zero operands SHALL follow the normal LOAD/RUN path unchanged.

Verification
REQ-030 Req0, A0=24, B0=36, model asserts gcd_Done with 12 after 9 RUN cycles -> one gcd_Start pulse, gcd_Ain=24, gcd_Bin=36, one gcd_Ack pulse, Rdy0=1, Result=12, Cycles=9.
REQ-031 Req0 and Req1 both held high for four jobs, Rack returned one cycle after Rdy -> grant order 0,1,0,1.
REQ-032 GCD_ZERO_CHECK_EN defined, Req1 with A1=0, B1=15 -> no gcd_Start, Rdy1=1, Result=15, Cycles=0; undefined -> gcd_Start pulse issued.
REQ-033 Reset low during RUN -> all outputs 0 in same cycle, IDLE after release, no Rdy for discarded job.
REQ-034 Rdy0 held with Rack0 low for 10 cycles while Req1 high -> Rdy0 and Result stable, no Grant1 until cycle after Rack0.
REQ-035 gcd_Done held low for 70000 cycles with CNT_W=16 -> Cycles saturates at 0xFFFF, no wrap.
